// File: rtl/usbfs_rx_pkt_buf.sv
// rtl/usbfs_rx_pkt_buf.sv - USB FS OUT DATA packet buffer with CRC strip, toggle check and handshake decision
module usbfs_rx_pkt_buf #(
  parameter  int MAX_PKT = 8,
  localparam int IW      = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1,
  localparam int CW      = $clog2(MAX_PKT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pktStart,
  input  logic          i_pktPid1,
  input  logic          i_byteValid,
  input  logic [7:0]    i_byte,
  input  logic          i_pktEnd,
  input  logic          i_pktErr,
  input  logic          i_toggleClr,
  output logic          o_hsAck,
  output logic          o_hsNak,
  output logic          o_hsStall,
  output logic          o_erValid,
  input  logic          i_erReady,
  input  logic          i_erStall,
  input  logic          i_erRdEn,
  input  logic [IW-1:0] i_erRdIdx,
  output logic [7:0]    o_erRdByte,
  output logic [CW-1:0] o_erRdNBytes
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  rx_state_e       state_q;
  logic            full_q;
  logic            tog_q;       // expected PID: 0=DATA0, 1=DATA1
  logic            pid_q;       // PID of the packet in flight
  logic [CW-1:0]   wr_cnt_q;
  logic [CW-1:0]   wr_cnt_d;
  logic [1:0]      dl_cnt_q;    // occupancy of the 2-byte CRC delay line
  logic [1:0]      dl_cnt_d;
  logic            ovf_q;
  logic            ovf_d;
  logic [7:0]      dl0_q;       // oldest byte in the delay line
  logic [7:0]      dl1_q;
  logic            mem_we;
  logic            hs_ack_q;
  logic            hs_nak_q;
  logic            hs_stall_q;
  logic [CW-1:0]   nbytes_q;
  logic [7:0]      rd_byte_q;
  logic [7:0]      mem_q [MAX_PKT];

  assign o_hsAck      = hs_ack_q;
  assign o_hsNak      = hs_nak_q;
  assign o_hsStall    = hs_stall_q;
  assign o_erValid    = full_q;
  assign o_erRdByte   = rd_byte_q;
  assign o_erRdNBytes = nbytes_q;

  // Effect of this cycle's byte, so an EOP in the same cycle sees it already counted
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    dl_cnt_d = dl_cnt_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (i_rst_n && state_q == ST_RECV && i_byteValid && !i_pktStart) begin
      if (dl_cnt_q == 2'd2) begin
        if (wr_cnt_q == CW'(MAX_PKT)) begin
          ovf_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
      end else begin
        dl_cnt_d = dl_cnt_q + 2'd1;
      end
    end
  end

  // Rx FSM, full flag, toggle tracking and registered handshake decision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      full_q     <= 1'b0;
      tog_q      <= 1'b0;
      pid_q      <= 1'b0;
      wr_cnt_q   <= '0;
      dl_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      dl0_q      <= '0;
      dl1_q      <= '0;
      hs_ack_q   <= 1'b0;
      hs_nak_q   <= 1'b0;
      hs_stall_q <= 1'b0;
      nbytes_q   <= '0;
    end else begin
      hs_ack_q   <= 1'b0;
      hs_nak_q   <= 1'b0;
      hs_stall_q <= 1'b0;

      if (full_q && i_erReady) begin
        full_q <= 1'b0;
      end

      if (i_pktStart) begin
        // A new PID always (re)starts reception; any packet in flight is abandoned silently
        pid_q    <= i_pktPid1;
        wr_cnt_q <= '0;
        dl_cnt_q <= '0;
        ovf_q    <= 1'b0;
        state_q  <= full_q ? ST_DROP : ST_RECV;
      end else begin
        case (state_q)
          ST_RECV: begin
            wr_cnt_q <= wr_cnt_d;
            dl_cnt_q <= dl_cnt_d;
            ovf_q    <= ovf_d;
            if (i_byteValid) begin
              case (dl_cnt_q)
                2'd0:    dl0_q <= i_byte;
                2'd1:    dl1_q <= i_byte;
                default: begin
                  dl0_q <= dl1_q;
                  dl1_q <= i_byte;
                end
              endcase
            end
            if (i_pktEnd) begin
              state_q <= ST_IDLE;
              if (i_pktErr || ovf_d || dl_cnt_d < 2'd2) begin
                // corrupt, oversized or runt packet: stay silent, host retries
              end else if (i_erStall) begin
                hs_stall_q <= 1'b1;
              end else if (pid_q != tog_q) begin
                hs_ack_q <= 1'b1;          // duplicate: ACK again, discard data
              end else begin
                hs_ack_q <= 1'b1;
                tog_q    <= ~tog_q;
                full_q   <= 1'b1;
                nbytes_q <= wr_cnt_d;
              end
            end
          end
          ST_DROP: begin
            if (i_pktEnd) begin
              state_q <= ST_IDLE;
              if (!i_pktErr) begin
                if (i_erStall) begin
                  hs_stall_q <= 1'b1;
                end else begin
                  hs_nak_q <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end

      // Clearing the toggle overrides a flip from a packet ending this cycle
      if (i_toggleClr) begin
        tog_q <= 1'b0;
      end
    end
  end

  // Payload storage; contents survive reset
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wr_cnt_q[IW-1:0]] <= dl0_q;
    end
  end

  // Registered random-access read port for the endpoint
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_byte_q <= '0;
    end else if (i_erRdEn) begin
      if (int'(i_erRdIdx) < MAX_PKT) begin
        rd_byte_q <= mem_q[i_erRdIdx];
      end else begin
        rd_byte_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_usbfs_rx_pkt_buf.sv
// tb/tb_usbfs_rx_pkt_buf.sv - self-checking bench for usbfs_rx_pkt_buf
module tb_usbfs_rx_pkt_buf;

  localparam int MAX_PKT = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_pktStart;
  logic          i_pktPid1;
  logic          i_byteValid;
  logic [7:0]    i_byte;
  logic          i_pktEnd;
  logic          i_pktErr;
  logic          i_toggleClr;
  logic          o_hsAck;
  logic          o_hsNak;
  logic          o_hsStall;
  logic          o_erValid;
  logic          i_erReady;
  logic          i_erStall;
  logic          i_erRdEn;
  logic [IW-1:0] i_erRdIdx;
  logic [7:0]    o_erRdByte;
  logic [CW-1:0] o_erRdNBytes;

  usbfs_rx_pkt_buf #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pktStart(i_pktStart), .i_pktPid1(i_pktPid1),
    .i_byteValid(i_byteValid), .i_byte(i_byte), .i_pktEnd(i_pktEnd), .i_pktErr(i_pktErr),
    .i_toggleClr(i_toggleClr), .o_hsAck(o_hsAck), .o_hsNak(o_hsNak), .o_hsStall(o_hsStall),
    .o_erValid(o_erValid), .i_erReady(i_erReady), .i_erStall(i_erStall), .i_erRdEn(i_erRdEn),
    .i_erRdIdx(i_erRdIdx), .o_erRdByte(o_erRdByte), .o_erRdNBytes(o_erRdNBytes)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  // Reference model state: what the endpoint should see
  logic [7:0] pkt_data [0:79];
  logic [7:0] m_mem [0:MAX_PKT-1];
  logic       m_full;
  logic       m_tog;
  int         m_n;

  typedef struct {
    logic pid; int n; logic err; logic stall; logic handoff; logic clr; int base;
    logic ack; logic nak; logic stl; logic valid; int nb; int rbase;
  } tv_t;

  localparam int NT = 14;
  tv_t tv [NT];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_pkt(input logic pid, input int n, input logic err, input logic stall,
                           output logic ea, output logic en, output logic es);
    ea = 1'b0; en = 1'b0; es = 1'b0;
    if (m_full) begin
      if (!err) begin
        if (stall) es = 1'b1; else en = 1'b1;
      end
    end else if (!err && n >= 2 && (n - 2) <= MAX_PKT) begin
      if (stall) es = 1'b1;
      else if (pid != m_tog) ea = 1'b1;
      else begin
        ea = 1'b1;
        m_tog = ~m_tog;
        m_full = 1'b1;
        m_n = n - 2;
        for (int i = 0; i < n - 2; i++) m_mem[i] = pkt_data[i];
      end
    end
  endtask

  task automatic send_pkt(input logic pid, input int n, input logic err, input logic stall,
                          input logic coinc, output logic ga, output logic gn, output logic gs);
    i_pktStart = 1'b1; i_pktPid1 = pid;
    @(negedge i_clk);
    i_pktStart = 1'b0; i_pktPid1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_byteValid = 1'b1; i_byte = pkt_data[i];
      if (coinc && i == n - 1) begin
        i_pktEnd = 1'b1; i_pktErr = err; i_erStall = stall;
      end
      @(negedge i_clk);
      i_byteValid = 1'b0; i_byte = 8'h00;
      if (!i_pktEnd) @(negedge i_clk);
    end
    if (!i_pktEnd) begin
      i_pktEnd = 1'b1; i_pktErr = err; i_erStall = stall;
      @(negedge i_clk);
    end
    i_pktEnd = 1'b0; i_pktErr = 1'b0; i_erStall = 1'b0;
    ga = o_hsAck; gn = o_hsNak; gs = o_hsStall;
    @(negedge i_clk);
    chk("hs_one_cycle", int'({o_hsAck, o_hsNak, o_hsStall}), 0);
  endtask

  task automatic do_handoff();
    i_erReady = 1'b1;
    @(negedge i_clk);
    i_erReady = 1'b0;
    @(negedge i_clk);
    m_full = 1'b0;
    chk("handoff_valid", int'(o_erValid), 0);
  endtask

  task automatic do_clr();
    i_toggleClr = 1'b1;
    @(negedge i_clk);
    i_toggleClr = 1'b0;
    m_tog = 1'b0;
  endtask

  task automatic read_chk(input string name, input int idx, input int exp);
    i_erRdEn = 1'b1; i_erRdIdx = IW'(idx);
    @(negedge i_clk);
    i_erRdEn = 1'b0; i_erRdIdx = '0;
    chk(name, int'(o_erRdByte), exp);
  endtask

  task automatic partial_pkt(input logic pid, input int n);
    i_pktStart = 1'b1; i_pktPid1 = pid;
    @(negedge i_clk);
    i_pktStart = 1'b0; i_pktPid1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_byteValid = 1'b1; i_byte = 8'(8'h90 + i);
      @(negedge i_clk);
      i_byteValid = 1'b0; i_byte = 8'h00;
      chk("partial_no_hs", int'({o_hsAck, o_hsNak, o_hsStall}), 0);
      @(negedge i_clk);
    end
  endtask

  function automatic tv_t mk(input logic pid, input int n, input logic err, input logic stall,
                             input logic handoff, input logic clr, input int base,
                             input logic ack, input logic nak, input logic stl,
                             input logic valid, input int nb, input int rbase);
    tv_t t;
    t.pid = pid; t.n = n; t.err = err; t.stall = stall; t.handoff = handoff; t.clr = clr;
    t.base = base; t.ack = ack; t.nak = nak; t.stl = stl; t.valid = valid; t.nb = nb;
    t.rbase = rbase;
    return t;
  endfunction

  logic ga, gn, gs, ea, en, es;

  initial begin
    //          pid n   err stl hof clr base  ack nak stl val nb rbase
    tv[0]  = mk(0,  5,  0,  0,  0,  0,  8'h01, 1,  0,  0,  1,  3, 8'h01);
    tv[1]  = mk(1,  4,  0,  0,  0,  0,  8'h40, 0,  1,  0,  1,  3, 8'h01);
    tv[2]  = mk(1,  4,  1,  0,  0,  0,  8'h48, 0,  0,  0,  1,  3, 8'h01);
    tv[3]  = mk(1,  10, 0,  0,  1,  0,  8'h10, 1,  0,  0,  1,  8, 8'h10);
    tv[4]  = mk(0,  11, 0,  0,  1,  0,  8'h60, 0,  0,  0,  0,  8, 0);
    tv[5]  = mk(0,  4,  0,  0,  0,  0,  8'h20, 1,  0,  0,  1,  2, 8'h20);
    tv[6]  = mk(0,  4,  0,  0,  1,  0,  8'h70, 1,  0,  0,  0,  2, 0);
    tv[7]  = mk(0,  3,  0,  0,  0,  1,  8'h30, 1,  0,  0,  1,  1, 8'h30);
    tv[8]  = mk(1,  5,  0,  1,  1,  0,  8'h78, 0,  0,  1,  0,  1, 0);
    tv[9]  = mk(1,  2,  0,  0,  0,  0,  8'hE0, 1,  0,  0,  1,  0, 0);
    tv[10] = mk(0,  4,  0,  1,  0,  0,  8'h80, 0,  0,  1,  1,  0, 0);
    tv[11] = mk(0,  1,  0,  0,  1,  0,  8'h88, 0,  0,  0,  0,  0, 0);
    tv[12] = mk(0,  5,  1,  0,  0,  0,  8'h8C, 0,  0,  0,  0,  0, 0);
    tv[13] = mk(0,  4,  0,  0,  0,  0,  8'h50, 1,  0,  0,  1,  2, 8'h50);

    i_rst_n = 1'b0; i_pktStart = 0; i_pktPid1 = 0; i_byteValid = 0; i_byte = 0;
    i_pktEnd = 0; i_pktErr = 0; i_toggleClr = 0; i_erReady = 0; i_erStall = 0;
    i_erRdEn = 0; i_erRdIdx = '0;
    m_full = 0; m_tog = 0; m_n = 0;
    for (int i = 0; i < MAX_PKT; i++) m_mem[i] = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_outputs", int'({o_hsAck, o_hsNak, o_hsStall, o_erValid}), 0);
    chk("rst_nbytes", int'(o_erRdNBytes), 0);
    chk("rst_rdbyte", int'(o_erRdByte), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed table
    for (int k = 0; k < NT; k++) begin
      if (tv[k].handoff) do_handoff();
      if (tv[k].clr) do_clr();
      for (int i = 0; i < tv[k].n; i++) pkt_data[i] = 8'(tv[k].base + i);
      send_pkt(tv[k].pid, tv[k].n, tv[k].err, tv[k].stall, (k % 2) == 1, ga, gn, gs);
      model_pkt(tv[k].pid, tv[k].n, tv[k].err, tv[k].stall, ea, en, es);
      chk($sformatf("t%0d_ack", k), int'(ga), int'(tv[k].ack));
      chk($sformatf("t%0d_nak", k), int'(gn), int'(tv[k].nak));
      chk($sformatf("t%0d_stall", k), int'(gs), int'(tv[k].stl));
      chk($sformatf("t%0d_valid", k), int'(o_erValid), int'(tv[k].valid));
      chk($sformatf("t%0d_nbytes", k), int'(o_erRdNBytes), tv[k].nb);
      if (tv[k].valid) begin
        for (int i = 0; i < tv[k].nb; i++)
          read_chk($sformatf("t%0d_rd%0d", k, i), i, int'(8'(tv[k].rbase + i)));
      end
    end

    // Read data holds while no strobe
    read_chk("rd_before_hold", 1, 8'h51);
    @(negedge i_clk);
    chk("rd_hold", int'(o_erRdByte), 8'h51);

    // Reset in the middle of a packet
    do_handoff();
    partial_pkt(1'b1, 3);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("midrst_outputs", int'({o_hsAck, o_hsNak, o_hsStall, o_erValid}), 0);
    chk("midrst_nbytes", int'(o_erRdNBytes), 0);
    chk("midrst_rdbyte", int'(o_erRdByte), 0);
    i_pktEnd = 1'b1;
    @(negedge i_clk);
    i_pktEnd = 1'b0;
    @(negedge i_clk);
    chk("midrst_no_hs", int'({o_hsAck, o_hsNak, o_hsStall}), 0);
    m_tog = 1'b0; m_full = 1'b0; m_n = 0;
    for (int i = 0; i < 5; i++) pkt_data[i] = 8'(8'hC0 + i);
    send_pkt(1'b0, 5, 1'b0, 1'b0, 1'b0, ga, gn, gs);
    model_pkt(1'b0, 5, 1'b0, 1'b0, ea, en, es);
    chk("postrst_ack", int'(ga), 1);
    chk("postrst_valid", int'(o_erValid), 1);
    read_chk("postrst_rd2", 2, 8'hC2);

    // Restart: new PID abandons packet in flight
    do_handoff();
    partial_pkt(1'b1, 4);
    for (int i = 0; i < 6; i++) pkt_data[i] = 8'(8'hA0 + i);
    send_pkt(1'b1, 6, 1'b0, 1'b0, 1'b1, ga, gn, gs);
    model_pkt(1'b1, 6, 1'b0, 1'b0, ea, en, es);
    chk("restart_ack", int'(ga), 1);
    chk("restart_nbytes", int'(o_erRdNBytes), 4);
    read_chk("restart_rd0", 0, 8'hA0);
    read_chk("restart_rd3", 3, 8'hA3);

    // Randomized packets against the model
    for (int r = 0; r < 40; r++) begin
      logic pid, err, stall, coinc;
      int n;
      if (m_full && $urandom_range(0, 1) == 1) do_handoff();
      if ($urandom_range(0, 9) == 0) do_clr();
      pid = 1'($urandom_range(0, 1));
      n = $urandom_range(0, MAX_PKT + 3);
      err = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 5) == 0);
      coinc = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) pkt_data[i] = 8'($urandom);
      send_pkt(pid, n, err, stall, coinc, ga, gn, gs);
      model_pkt(pid, n, err, stall, ea, en, es);
      chk($sformatf("r%0d_ack", r), int'(ga), int'(ea));
      chk($sformatf("r%0d_nak", r), int'(gn), int'(en));
      chk($sformatf("r%0d_stall", r), int'(gs), int'(es));
      chk($sformatf("r%0d_valid", r), int'(o_erValid), int'(m_full));
      chk($sformatf("r%0d_nbytes", r), int'(o_erRdNBytes), m_n);
      if (m_full) begin
        for (int i = 0; i < m_n; i++)
          read_chk($sformatf("r%0d_rd%0d", r, i), i, int'(m_mem[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
